// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_arb_state_t;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the core and loader requests.
// Round-robin tie-breaking when MEM_ARB_RR_EN is defined, fixed priority otherwise.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic winner,
    output logic valid
);

`ifdef MEM_ARB_RR_EN
    // Ties go to the port that was not granted last
    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CORE;
        if (req0 && req1) begin
            winner = (last_gnt == PORT_CORE) ? PORT_LOADER : PORT_CORE;
        end else if (req1) begin
            winner = PORT_LOADER;
        end else begin
            winner = PORT_CORE;
        end
    end
`else
    logic unused_last_gnt_s;
    assign unused_last_gnt_s = last_gnt;

    // Core always beats the loader
    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CORE;
        if (req0) begin
            winner = PORT_CORE;
        end else if (req1) begin
            winner = PORT_LOADER;
        end else begin
            winner = PORT_CORE;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port fixed-latency BRAM between the core (port 0) and the
// UART loader (port 1). Optional round-robin arbitration: MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int AW     = 17,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    import mem_arb_pkg::*;

    localparam int            CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    mem_arb_state_t state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic           owner_r, owner_s;
    logic [DW-1:0]  rdata_r, rdata_s;
    logic           gnt0_r, gnt0_s, gnt1_r, gnt1_s;
    logic           rvalid0_r, rvalid0_s, rvalid1_r, rvalid1_s;
    logic           busy_r, busy_s;
    logic           mem_en_r, mem_en_s, mem_we_r, mem_we_s;
    logic [AW-1:0]  mem_addr_r, mem_addr_s;
    logic [DW-1:0]  mem_wdata_r, mem_wdata_s;
    logic           last_gnt_s;
    logic           win_idx_s, win_vld_s;

    mem_arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt_s),
        .winner   (win_idx_s),
        .valid    (win_vld_s)
    );

`ifdef MEM_ARB_RR_EN
    logic last_gnt_r;

    // Remember which port took the most recent grant
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_gnt_r <= 1'b1;
        end else if ((state_r == IDLE) && win_vld_s) begin
            last_gnt_r <= win_idx_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    assign last_gnt_s = last_gnt_r;
`else
    assign last_gnt_s = 1'b1;
`endif

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        owner_s     = owner_r;
        rdata_s     = rdata_r;
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        rvalid0_s   = 1'b0;
        rvalid1_s   = 1'b0;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        case (state_r)
            IDLE: begin
                if (win_vld_s) begin
                    state_s  = ISSUE;
                    owner_s  = win_idx_s;
                    mem_en_s = 1'b1;
                    if (win_idx_s == PORT_LOADER) begin
                        mem_we_s    = we1;
                        mem_addr_s  = addr1;
                        mem_wdata_s = wdata1;
                        gnt1_s      = 1'b1;
                    end else begin
                        mem_we_s    = we0;
                        mem_addr_s  = addr0;
                        mem_wdata_s = wdata0;
                        gnt0_s      = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // mem_we_r still reflects the command issued this cycle
                if (mem_we_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                    cnt_s   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s   = RESP;
                    rdata_s   = mem_rdata;
                    rvalid0_s = (owner_r == PORT_CORE);
                    rvalid1_s = (owner_r == PORT_LOADER);
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State, counter, owner and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            owner_r     <= PORT_CORE;
            rdata_r     <= {DW{1'b0}};
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            rvalid0_r   <= 1'b0;
            rvalid1_r   <= 1'b0;
            busy_r      <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            owner_r     <= owner_s;
            rdata_r     <= rdata_s;
            gnt0_r      <= gnt0_s;
            gnt1_r      <= gnt1_s;
            rvalid0_r   <= rvalid0_s;
            rvalid1_r   <= rvalid1_s;
            busy_r      <= busy_s;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign gnt0      = gnt0_r;
    assign gnt1      = gnt1_r;
    assign rvalid0   = rvalid0_r;
    assign rvalid1   = rvalid1_r;
    assign rdata     = rdata_r;
    assign busy      = busy_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule
